// File: rtl/hazard_controller.sv
// hazard_controller: load-use, branch-operand and multi-cycle EX stall/flush sequencer.
// Optional HAZARD_PERF_EN adds 16-bit stall and flush event counters.
module hazard_controller #(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_take,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_rd,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             ex_mc_start,
    input  logic [LAT_W-1:0] ex_mc_lat,
    output logic             holdPC,
    output logic             hold_if_id,
    output logic             flush,
    output logic             bubble_id_ex,
    output logic             hold_id_ex,
    output logic             bubble_ex_mem,
    output logic             mc_busy
`ifdef HAZARD_PERF_EN
   ,output logic [15:0]      perf_stall_cnt,
    output logic [15:0]      perf_flush_cnt
`endif
);
    typedef enum logic [1:0] {RUN, BUSY, LAST} state_t;
    state_t state, state_n;
    logic [LAT_W-1:0] cnt, cnt_n;
    logic ex_hit, mem_hit, ld_stall, br_stall, id_stall, mc_stall, hold;
    assign ex_hit   = ex_rd != 5'd0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    assign mem_hit  = mem_rd != 5'd0 && (mem_rd == id_rs || (id_uses_rt && mem_rd == id_rt));
    assign ld_stall = ex_mem_read && ex_hit;
    assign br_stall = id_is_branch && ((ex_reg_write && ex_hit) || (mem_mem_read && mem_hit));
    assign id_stall = ld_stall || br_stall;
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mc_stall = 1'b0;
        case (state)
            RUN: if (ex_mc_start && ex_mc_lat >= LAT_W'(2)) begin
                mc_stall = 1'b1;
                state_n  = ex_mc_lat == LAT_W'(2) ? LAST : BUSY;
                cnt_n    = ex_mc_lat - LAT_W'(3);
            end
            BUSY: begin
                mc_stall = 1'b1;
                state_n  = cnt == '0 ? LAST : BUSY;
                cnt_n    = cnt == '0 ? cnt : cnt - LAT_W'(1);
            end
            default: state_n = RUN;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // Reset forces every control low, even while a BUSY state is still registered.
    assign hold          = !rst && (mc_stall || id_stall);
    assign holdPC        = hold;
    assign hold_if_id    = hold;
    assign bubble_id_ex  = !rst && id_stall && !mc_stall;
    assign hold_id_ex    = !rst && mc_stall;
    assign bubble_ex_mem = !rst && mc_stall;
    assign flush         = !rst && id_take && !id_stall && !mc_stall;
    assign mc_busy       = !rst && state != RUN;
`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + {15'd0, holdPC};
            perf_flush_cnt <= perf_flush_cnt + {15'd0, flush};
        end
    end
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors with a queue scoreboard checked at negedge.
module tb_hazard_controller;
    localparam int LAT_W = 4;
    localparam logic [6:0] Z   = 7'b0000000;
    localparam logic [6:0] IDS = 7'b1101000;
    localparam logic [6:0] MC0 = 7'b1100110;
    localparam logic [6:0] MCB = 7'b1100111;
    localparam logic [6:0] LST = 7'b0000001;
    localparam logic [6:0] FL  = 7'b0010000;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic id_uses_rt, id_is_branch, id_take, ex_mem_read, ex_reg_write, mem_mem_read, ex_mc_start;
    logic [LAT_W-1:0] ex_mc_lat;
    logic holdPC, hold_if_id, flush, bubble_id_ex, hold_id_ex, bubble_ex_mem, mc_busy;
`ifdef HAZARD_PERF_EN
    logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif
    hazard_controller #(.LAT_W(LAT_W)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_take(id_take), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
        .ex_mc_start(ex_mc_start), .ex_mc_lat(ex_mc_lat), .holdPC(holdPC), .hold_if_id(hold_if_id),
        .flush(flush), .bubble_id_ex(bubble_id_ex), .hold_id_ex(hold_id_ex),
        .bubble_ex_mem(bubble_ex_mem), .mc_busy(mc_busy)
`ifdef HAZARD_PERF_EN
       ,.perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [6:0]  v;
        logic [15:0] es;
        logic [15:0] ef;
        string       n;
    } item_t;
    item_t q[$];
    int n_vec = 0;
    int n_err = 0;
    int m_stall = 0;
    int m_flush = 0;
    logic [6:0] obs;
    assign obs = {holdPC, hold_if_id, flush, bubble_id_ex, hold_id_ex, bubble_ex_mem, mc_busy};
    always @(negedge clk) begin
        item_t it;
        if (q.size() > 0) begin
            it = q.pop_front();
            n_vec++;
            if (obs !== it.v) begin
                n_err++;
                $display("FAIL %s: outputs=%b required=%b", it.n, obs, it.v);
            end
`ifdef HAZARD_PERF_EN
            n_vec++;
            if (perf_stall_cnt !== it.es || perf_flush_cnt !== it.ef) begin
                n_err++;
                $display("FAIL %s_perf: stall_cnt=%h flush_cnt=%h required %h %h",
                         it.n, perf_stall_cnt, perf_flush_cnt, it.es, it.ef);
            end
`endif
        end
    end
    task automatic step(input logic [6:0] e, input string nm);
        item_t it;
        it.v  = e;
        it.es = m_stall[15:0];
        it.ef = m_flush[15:0];
        it.n  = nm;
        q.push_back(it);
        if (rst) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            m_stall += int'(e[6]);
            m_flush += int'(e[4]);
        end
        @(posedge clk);
        #1;
    endtask
    task automatic clr();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_is_branch = 0; id_take = 0;
        ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; mem_mem_read = 0; mem_rd = 0;
        ex_mc_start = 0; ex_mc_lat = 0;
    endtask
    initial begin
        rst = 1;
        clr();
        @(posedge clk);
        #1;
        ex_mc_start = 1; ex_mc_lat = 5; id_take = 1; ex_mem_read = 1; ex_rd = 8; id_rs = 8;
        step(Z, "reset_outputs_zero");
        step(Z, "reset_held");
        rst = 0;
        clr();
        step(Z, "idle");
        ex_mem_read = 1; ex_rd = 8; id_rs = 8;
        step(IDS, "load_use");
        ex_mem_read = 0;
        step(Z, "load_use_release");
        ex_mem_read = 1; ex_rd = 0; id_rs = 0;
        step(Z, "load_use_r0");
        ex_rd = 8; id_rs = 1; id_rt = 8; id_uses_rt = 0;
        step(Z, "rt_unused");
        id_uses_rt = 1;
        step(IDS, "load_use_rt");
        clr();
        id_is_branch = 1; id_rs = 3; id_rt = 9; id_uses_rt = 1; id_take = 1;
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 9;
        step(IDS, "br_load_c0");
        ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; mem_mem_read = 1; mem_rd = 9;
        step(IDS, "br_load_c1");
        mem_mem_read = 0;
        step(FL, "br_load_flush");
        ex_reg_write = 1; ex_rd = 3;
        step(IDS, "br_alu_stall");
        ex_reg_write = 0;
        step(FL, "br_alu_flush");
        id_take = 0;
        step(Z, "br_not_taken");
        id_is_branch = 0; ex_reg_write = 1; ex_rd = 3;
        step(Z, "alu_no_branch");
        clr();
        ex_mc_start = 1; ex_mc_lat = 5;
        step(MC0, "mc5_c0");
        repeat (3) step(MCB, "mc5_busy");
        step(LST, "mc5_last_no_retrigger");
        ex_mc_start = 0;
        step(Z, "mc5_done");
        ex_mc_start = 1; ex_mc_lat = 1;
        step(Z, "mc_lat1");
        ex_mc_lat = 0;
        step(Z, "mc_lat0");
        ex_mc_lat = 2;
        step(MC0, "mc2_c0");
        step(LST, "mc2_last");
        step(MC0, "mc2_next_instr");
        step(LST, "mc2_last2");
        ex_mc_start = 0;
        step(Z, "mc2_done");
        ex_mc_start = 1; ex_mc_lat = 4;
        step(MC0, "mc4_c0");
        ex_mc_lat = 15; ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_take = 1;
        step(MCB, "busy_ld_take");
        step(MCB, "busy_ld_take_lat_change");
        step(IDS | LST, "last_id_stall");
        clr();
        step(Z, "simul_done");
        ex_mc_start = 1; ex_mc_lat = 9;
        step(MC0, "mc9_c0");
        step(MCB, "mc9_c1");
        step(MCB, "mc9_c2");
        rst = 1; id_take = 1;
        step(Z, "rst_mid_busy");
        rst = 0; id_take = 0;
        step(MC0, "post_rst_accept");
        repeat (7) step(MCB, "mc9b_busy");
        step(LST, "mc9b_last");
        ex_mc_start = 0;
        step(Z, "mc9b_done");
`ifdef HAZARD_PERF_EN
        rst = 1;
        step(Z, "perf_clear");
        rst = 0;
        ex_mem_read = 1; ex_rd = 8; id_rs = 8;
        repeat (65537) step(IDS, "perf_wrap");
        clr();
        step(Z, "perf_wrapped");
`endif
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Stall/flush sequencer for the 5-stage pipelined datapath. It combines three sources of pipeline disruption into the hold/flush/bubble controls consumed by PC, IF_ID, ID_EX and EX_MEM:
- load-use hazards;
- branch/jump redirects resolved in ID, including operand-not-ready stalls for branches;
- multi-cycle EX operations (mult/div).

It sits beside the datapath and owns the only sequential stall state in the pipeline.

## Interface
Parameters:
- LAT_W, 4, width of the multi-cycle latency field (max latency 2^LAT_W−1)

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- id_rs  input  5  rs field of instruction in ID
- id_rt  input  5  rt field of instruction in ID
- id_uses_rt  input  1  ID instruction reads rt
- id_is_branch  input  1  ID holds beq/bne (compares in ID)
- id_take  input  1  branch taken / jump, valid when not stalled
- ex_mem_read  input  1  EX instruction is a load
- ex_reg_write  input  1  EX instruction writes a register
- ex_rd  input  5  destination register of EX instruction (post RegDst mux)
- mem_mem_read  input  1  MEM instruction is a load
- mem_rd  input  5  destination register of MEM instruction
- ex_mc_start  input  1  EX holds a multi-cycle op (held high while it sits in EX)
- ex_mc_lat  input  LAT_W  total EX cycles of that op
- holdPC  output  1  freeze PC
- hold_if_id  output  1  freeze IF_ID
- flush  output  1  clear IF_ID (squash fetched instruction)
- bubble_id_ex  output  1  load zero controls into ID_EX
- hold_id_ex  output  1  freeze ID_EX
- bubble_ex_mem  output  1  load zero controls into EX_MEM
- mc_busy  output  1  multi-cycle stall in progress (state ≠ RUN)

## Operation
- Hazard match m(r, d) = (d ≠ 0) && (d == id_rs || (id_uses_rt && d == id_rt)); r is the qualifying control bit.
- ld_stall = ex_mem_read && m(ex_rd).
- br_stall = id_is_branch && ((ex_reg_write && m(ex_rd)) || (mem_mem_read && m(mem_rd))).
- id_stall = ld_stall || br_stall → holdPC=1, hold_if_id=1, bubble_id_ex=1.
- FSM states: RUN, BUSY, LAST; down-counter cnt[LAT_W-1:0].
  - RUN:
    - If ex_mc_start && ex_mc_lat ≥ 2, assert mc_stall this cycle.
    - If lat==2, next state is LAST. Otherwise next state is BUSY with cnt ← lat−3.
    - If lat ≤ 1, no stall and the FSM stays in RUN.
  - BUSY: mc_stall=1; if cnt==0 → LAST, else cnt−1.
  - LAST: no mc_stall; ex_mc_start ignored; next state RUN.
  - Net effect: L−1 frozen cycles for latency L.
- mc_stall → holdPC, hold_if_id, hold_id_ex, bubble_ex_mem = 1; bubble_id_ex = 0; flush = 0.
- Priority: mc_stall > id_stall > flush. flush = id_take && !id_stall && !mc_stall.
- id_stall is evaluated in every state. Its outputs are masked while mc_stall=1 (hold wins over bubble).
- mc_busy = (state ≠ RUN).

## Timing
- All hazard outputs are combinational from inputs and registered state, valid in the same cycle. There is no added latency.
- Reset: state=RUN, cnt=0. All outputs are 0 while rst=1 regardless of inputs, and stall counters are cleared.
- Reset during BUSY aborts the sequence; the next cycle is RUN.
- Load feeding a branch: 2 stall cycles (one from ex_mem_read, then one from mem_mem_read).
- ALU result feeding a branch: 1 stall cycle.
- An ex_mc_start that remains high in LAST must not retrigger.
- A new ex_mc_start in the first RUN cycle after LAST is accepted; it belongs to the next instruction.
- If ex_mc_lat changes while in BUSY, the change is ignored.

## Configuration
- Macro HAZARD_PERF_EN.
- When defined, the block adds two outputs:
  - perf_stall_cnt (16 bit): +1 each cycle holdPC=1.
  - perf_flush_cnt (16 bit): +1 each cycle flush=1.
- Both counters wrap at 0xFFFF→0 and clear on rst.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8.
  - Required: holdPC=hold_if_id=bubble_id_ex=1 for 1 cycle.
  - Same stimulus with ex_rd=0: no stall.
- Branch after load: id_is_branch=1, id_rt=9, id_uses_rt=1.
  - Cycle 0: ex_mem_read=1, ex_rd=9. Cycle 1: mem_mem_read=1, mem_rd=9.
  - Required: stall on cycles 0 and 1, then id_take=1 gives flush=1 on cycle 2.
- Multi-cycle: ex_mc_start=1, ex_mc_lat=5, held for 5 cycles.
  - Required: holdPC/hold_id_ex/bubble_ex_mem=1 for exactly 4 cycles, mc_busy=1 for cycles 1–4, no retrigger in LAST.
  - lat=1: no stall.
- Simultaneous events: during BUSY, assert ld_stall and id_take=1.
  - Required: flush=0, bubble_id_ex=0, holds=1.
- Reset mid-BUSY (lat=9, rst at cycle 3).
  - Required: all outputs 0 while rst; state RUN the next cycle; a new ex_mc_start is accepted.
- With HAZARD_PERF_EN: run the above sequence.
  - Required: perf_stall_cnt equals the holdPC cycle count and perf_flush_cnt=1.
  - Preload 0xFFFF via 65535 stalls, then one more stall wraps the counter to 0.
